dot_product_accumulator: RTL and testbench
==========================================

Name: dot_product_accumulator

Overview:
Sequencer and accumulator placed directly upstream and downstream of the single-cycle fixed-point multiplier.
- Accepts a stream of operand pairs over a valid/ready handshake.
- Drives the multiplier's operand and refresh inputs, then sums the returned products into a wide accumulator.
- Reports one N-bit fixed-point dot-product result per start request, with sticky overflow/saturation status.
- Used by matrix/vector stages that need length-L inner products.

Parameters:
N, 22, total fixed-point width (must match the multiplier)
Q, 10, fractional bits (must match the multiplier)
LEN_W, 6, width of the vector-length field; max length 2^LEN_W-1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a new dot product (sampled only in IDLE)
len  in  LEN_W  number of operand pairs; sampled with start
in_valid  in  1  operand pair valid
in_ready  out  1  block accepts operand pair
in_a  in  N  operand A, signed Q-format
in_b  in  N  operand B, signed Q-format
mult_refresh  out  1  to multiplier refresh
mult_in_1  out  N  to multiplier input_q_1
mult_in_2  out  N  to multiplier input_q_2
mult_out  in  N  from multiplier output_q
mult_overflow  in  1  from multiplier overflow
busy  out  1  high outside IDLE
result  out  N  dot-product result, held until next start
result_valid  out  1  one-cycle pulse when result is updated
ovf_flag  out  1  sticky: any multiplier overflow or accumulator saturation in the current job

Behaviour:
- Clocking: single clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - State goes to IDLE; accumulator, count, result and the delayed-refresh register are cleared.
  - in_ready=0, mult_refresh=0, busy=0, result=0, result_valid=0, ovf_flag=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 with len>0: clear accumulator and ovf_flag, load count=len, go to RUN.
  - start=1 with len=0: go to DONE with result=0.
  - start while not IDLE is ignored.
- RUN:
  - in_ready=1.
  - Handshake (in_valid & in_ready) in cycle t:
    - mult_in_1=in_a, mult_in_2=in_b and mult_refresh=1, all combinational in cycle t.
    - count decrements.
    - If this handshake is the last (count==1), go to DRAIN.
  - When there is no handshake: mult_refresh=0 and the mult_in_* outputs hold their last value.
- Multiplier latency: the product is available on mult_out in cycle t+1. A registered refresh_d flag marks it.
  - When refresh_d=1: accumulator += sign-extended mult_out.
  - If mult_overflow=1 in that same cycle: set ovf_flag.
  - Back-to-back handshakes are accepted every cycle at full throughput.
- DRAIN:
  - in_ready=0.
  - The final product is accumulated this cycle; go to DONE.
- DONE:
  - Register result; pulse result_valid=1 for one cycle; go to IDLE.
  - result_valid therefore rises 2 cycles after the last handshake.
- Accumulator:
  - Width N+LEN_W, signed.
  - No Q shift is applied; products are already in Q format.
- Result conversion:
  - If the accumulator fits in the N-bit signed range, result = accumulator[N-1:0].
  - Otherwise apply the behaviour under Optional Feature.
- ovf_flag is sticky until the next accepted start.
- Reset mid-job: everything aborts to the reset state immediately; any partial sum is discarded.

Optional Feature:
DOT_PRODUCT_SATURATE_EN
- Defined: out-of-range accumulator clamps result to +(2^(N-1)-1) or -2^(N-1), and sets ovf_flag.
- Undefined: result = accumulator[N-1:0] (two's-complement wrap), and accumulator range does not affect ovf_flag. Multiplier overflow still sets ovf_flag.

Test Plan:
1. len=3, a={1.0,2.0,-0.5}={1024,2048,-512}, b={3.0,0.5,4.0}, in_valid continuous -> mult_refresh high for 3 consecutive cycles; result=2048 (2.0); result_valid 2 cycles after the 3rd handshake; ovf_flag=0.
2. len=4, in_valid toggled 1/0 each cycle, all a=b=1024 -> 4 handshakes over 7 cycles; mult_refresh only on handshake cycles; result=4096 (4.0).
3. len=2, a=b=40.0 (40960) -> accumulator 3200.0.
   - SATURATE_EN defined: result=0x1FFFFF, ovf_flag=1.
   - Undefined: result = low 22 bits of 3276800, ovf_flag=0.
4. start with len=0 -> result=0 and result_valid one cycle later; no mult_refresh; busy high for exactly 1 cycle.
5. start asserted during RUN, and a second start one cycle after result_valid -> the first is ignored; the second restarts with cleared accumulator and ovf_flag.
6. rst_n pulsed low mid-RUN after 2 of 5 pairs -> all outputs reset asynchronously; a following start with len=1, a=b=1024 gives result=1024 with no residue.

Source files
------------

// File: rtl/dot_product_accumulator.sv
// Operand sequencer and wide accumulator wrapped around a single-cycle fixed-point multiplier.
// Optional macro DOT_PRODUCT_SATURATE_EN clamps out-of-range results instead of wrapping.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting operand pairs, one per cycle
// DRAIN | last product returning from the multiplier
// DONE  | result registered, result_valid high
module dot_product_accumulator #(
    parameter int N     = 22,
    parameter int Q     = 10,
    parameter int LEN_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    output logic             mult_refresh,
    output logic [N-1:0]     mult_in_1,
    output logic [N-1:0]     mult_in_2,
    input  logic [N-1:0]     mult_out,
    input  logic             mult_overflow,
    output logic             busy,
    output logic [N-1:0]     result,
    output logic             result_valid,
    output logic             ovf_flag
);

    localparam int AW = N + LEN_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    generate
        if (Q < 0 || Q >= N) begin : g_bad_q
            $error("dot_product_accumulator: Q must lie in [0, N-1]");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [N-1:0]     result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic             ovf_q, ovf_d;
    logic             refresh_d_q, refresh_d_d;
    logic [N-1:0]     mult_a_q, mult_a_d;
    logic [N-1:0]     mult_b_q, mult_b_d;

    logic             hs;
    logic [AW-1:0]    acc_sum;

`ifdef DOT_PRODUCT_SATURATE_EN
    localparam logic [N-1:0] RES_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] RES_MIN = {1'b1, {(N-1){1'b0}}};
    logic fits;
    // In range when every bit above the result sign bit repeats it.
    assign fits = (&acc_sum[AW-1:N-1]) | ~(|acc_sum[AW-1:N-1]);
`endif

    assign hs           = (state_q == S_RUN) && in_valid;
    assign in_ready     = (state_q == S_RUN);
    assign mult_refresh = hs;
    assign mult_in_1    = hs ? in_a : mult_a_q;
    assign mult_in_2    = hs ? in_b : mult_b_q;
    assign busy         = (state_q != S_IDLE);
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign ovf_flag     = ovf_q;

    assign acc_sum = refresh_d_q ? acc_q + {{LEN_W{mult_out[N-1]}}, mult_out} : acc_q;

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_sum;
        count_d        = count_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        ovf_d          = ovf_q | (refresh_d_q & mult_overflow);
        refresh_d_d    = hs;
        mult_a_d       = mult_in_1;
        mult_b_d       = mult_in_2;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (len != '0) begin
                        count_d = len;
                        state_d = S_RUN;
                    end else begin
                        result_d       = '0;
                        result_valid_d = 1'b1;
                        state_d        = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (hs) begin
                    count_d = count_q - LEN_W'(1);
                    if (count_q == LEN_W'(1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                result_valid_d = 1'b1;
                state_d        = S_DONE;
`ifdef DOT_PRODUCT_SATURATE_EN
                if (!fits) begin
                    result_d = acc_sum[AW-1] ? RES_MIN : RES_MAX;
                    ovf_d    = 1'b1;
                end else begin
                    result_d = acc_sum[N-1:0];
                end
`else
                result_d = acc_sum[N-1:0];
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            acc_q          <= '0;
            count_q        <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            ovf_q          <= 1'b0;
            refresh_d_q    <= 1'b0;
            mult_a_q       <= '0;
            mult_b_q       <= '0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            count_q        <= count_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            ovf_q          <= ovf_d;
            refresh_d_q    <= refresh_d_d;
            mult_a_q       <= mult_a_d;
            mult_b_q       <= mult_b_d;
        end
    end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Scoreboard bench for dot_product_accumulator with a behavioural Q-format multiplier attached.
module tb_dot_product_accumulator;

    localparam int N     = 22;
    localparam int Q     = 10;
    localparam int LEN_W = 6;
    localparam longint MAXV = (longint'(1) <<< (N - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (N - 1));

    typedef logic [N-1:0] word_t;
    typedef struct {
        word_t res;
        logic  ovf;
        logic  lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    word_t            in_a, in_b;
    logic             mult_refresh;
    word_t            mult_in_1, mult_in_2;
    word_t            mult_out;
    logic             mult_overflow;
    logic             busy;
    word_t            result;
    logic             result_valid;
    logic             ovf_flag;

    dot_product_accumulator #(.N(N), .Q(Q), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mult_refresh(mult_refresh), .mult_in_1(mult_in_1), .mult_in_2(mult_in_2),
        .mult_out(mult_out), .mult_overflow(mult_overflow),
        .busy(busy), .result(result), .result_valid(result_valid), .ovf_flag(ovf_flag)
    );

    always #5 clk = ~clk;

    // Single-cycle multiplier: product registered on refresh, overflow when out of N-bit range.
    always @(posedge clk or negedge rst_n) begin
        longint p;
        if (!rst_n) begin
            mult_out      <= '0;
            mult_overflow <= 1'b0;
        end else if (mult_refresh) begin
            p = (longint'($signed(mult_in_1)) * longint'($signed(mult_in_2))) >>> Q;
            mult_out      <= p[N-1:0];
            mult_overflow <= (p > MAXV) || (p < MINV);
        end else begin
            mult_overflow <= 1'b0;
        end
    end

    int   pass_cnt = 0;
    int   total_cnt = 0;
    exp_t sb[$];
    word_t va[$];
    word_t vb[$];

    int cyc = 0, last_hs = 0, hs_cnt = 0, ref_cnt = 0, busy_cnt = 0, rv_cnt = 0, mism = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_t e;
        if (in_valid && in_ready) begin
            hs_cnt++;
            last_hs = cyc;
            if (mult_in_1 !== in_a || mult_in_2 !== in_b) mism++;
        end
        if (mult_refresh !== (in_valid && in_ready)) mism++;
        if (mult_refresh) ref_cnt++;
        if (busy) busy_cnt++;
        if (result_valid) begin
            rv_cnt++;
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL sb_underflow: got result %0d with no expected entry, required none", result);
            end else begin
                e = sb.pop_front();
                chk("result", longint'(result), longint'(e.res));
                chk("ovf_flag", longint'(ovf_flag), longint'(e.ovf));
                if (e.lat) chk("result_latency", longint'(cyc - last_hs), 2);
            end
        end
    end

    task automatic add_pair(input int a, input int b);
        va.push_back(word_t'(a));
        vb.push_back(word_t'(b));
    endtask

    task automatic clear_pairs();
        va.delete();
        vb.delete();
    endtask

    task automatic run_job(input int L, input bit toggle, input bit mid_start,
                           input int er, input logic eo);
        int i, n, ref0, mism0, rv0, busy0;
        bit v, hs;
        exp_t e;
        ref0 = ref_cnt; mism0 = mism; rv0 = rv_cnt; busy0 = busy_cnt;
        e.res = word_t'(er); e.ovf = eo; e.lat = (L != 0);
        sb.push_back(e);
        start = 1'b1;
        len = LEN_W'(L);
        @(posedge clk); #1;
        start = 1'b0;
        len = '0;
        i = 0; n = 0; v = 1'b1;
        while (i < L && n < 200) begin
            in_valid = v;
            in_a = va[i];
            in_b = vb[i];
            if (mid_start && n == 0) start = 1'b1;
            hs = v && in_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (hs) i++;
            if (toggle) v = !v;
            n++;
        end
        in_valid = 1'b0;
        if (L != 0) chk("handshake_cycles", longint'(n), toggle ? longint'(2 * L - 1) : longint'(L));
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("job_completes", longint'(busy), 0);
        chk("refresh_count", longint'(ref_cnt - ref0), longint'(L));
        chk("refresh_protocol", longint'(mism - mism0), 0);
        chk("result_valid_pulses", longint'(rv_cnt - rv0), 1);
        if (L == 0) chk("busy_cycles", longint'(busy_cnt - busy0), 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, longint'(in_ready), 0);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_mult_refresh"}, longint'(mult_refresh), 0);
        chk({tag, "_result"}, longint'(result), 0);
        chk({tag, "_result_valid"}, longint'(result_valid), 0);
        chk({tag, "_ovf_flag"}, longint'(ovf_flag), 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
        in_a = '0; in_b = '0;
        #2;
        chk_reset_outputs("por");
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // a = {1.0, 2.0, -0.5}, b = {3.0, 0.5, 4.0}: 3.0 + 1.0 - 2.0 = 2.0
        clear_pairs();
        add_pair(1024, 3072); add_pair(2048, 512); add_pair(-512, 4096);
        run_job(3, 1'b0, 1'b0, 2048, 1'b0);

        // Four 1.0*1.0 products with in_valid toggling
        clear_pairs();
        repeat (4) add_pair(1024, 1024);
        run_job(4, 1'b1, 1'b0, 4096, 1'b0);

        // 40.0*40.0 twice = 3200.0, beyond the 22-bit range
        clear_pairs();
        add_pair(40960, 40960); add_pair(40960, 40960);
`ifdef DOT_PRODUCT_SATURATE_EN
        run_job(2, 1'b0, 1'b0, 32'h1FFFFF, 1'b1);
`else
        run_job(2, 1'b0, 1'b0, 3276800, 1'b0);
`endif

        // Zero length
        clear_pairs();
        run_job(0, 1'b0, 1'b0, 0, 1'b0);

        // 1500.0*1500.0 overflows the multiplier (wraps to 1327104); start during RUN ignored
        clear_pairs();
        add_pair(1536000, 1536000); add_pair(1024, 1024);
        run_job(2, 1'b0, 1'b1, 1328128, 1'b1);
        // Restart one cycle after result_valid: accumulator and ovf_flag cleared
        clear_pairs();
        add_pair(1024, 1024); add_pair(1024, 1024);
        run_job(2, 1'b0, 1'b0, 2048, 1'b0);
        clear_pairs();
        add_pair(1536000, 1536000);
        run_job(1, 1'b0, 1'b0, 1327104, 1'b1);

        // Reset after 2 of 5 pairs
        start = 1'b1; len = LEN_W'(5);
        @(posedge clk); #1;
        start = 1'b0; len = '0;
        in_valid = 1'b1; in_a = word_t'(1024); in_b = word_t'(1024);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        #4 rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        clear_pairs();
        add_pair(1024, 1024);
        run_job(1, 1'b0, 1'b0, 1024, 1'b0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", longint'(sb.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
